voice_allocator: RTL and testbench

//  Shares NUM_VOICES oscillator voices among NUM_KEYS piano keys: assigns each new key press to a voice, frees the voice on release.

---
 rtl/voice_allocator.sv | 171 +++++++++++++++++
 tb/tb_voice_allocator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES oscillator voices among NUM_KEYS keys.
// Each new key press is queued as pending, and one pending key is granted per
// cycle, lowest key index first. The grant goes to the lowest free voice. If
// every voice is busy, the oldest voice is stolen. Releasing a key frees its
// voice at the same edge.
//
// Ports:
//   clk          system clock
//   n_rst        synchronous active-low reset
//   enable       1 = allocate, 0 = flush voices and pending presses
//   keys         level key-held vector (debounced)
//   voice_active per-voice sounding flag
//   voice_key    per-voice key index, voice v at [v*KW +: KW]
//   voice_start  1-cycle pulse when voice v is (re)assigned
//   steal        1-cycle pulse alongside a voice_start caused by stealing
//   busy         at least one press is pending
module voice_allocator #(
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned NUM_VOICES = 4,
  localparam int unsigned KW = $clog2(NUM_KEYS),
  localparam int unsigned AW = $clog2(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       enable,
  input  logic [NUM_KEYS-1:0]        keys,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic [NUM_VOICES*KW-1:0]   voice_key,
  output logic [NUM_VOICES-1:0]      voice_start,
  output logic                       steal,
  output logic                       busy
);

  logic [NUM_KEYS-1:0]   key_q, key_d;
  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [KW-1:0]         vkey_q [NUM_VOICES];
  logic [KW-1:0]         vkey_d [NUM_VOICES];
  logic [AW-1:0]         age_q  [NUM_VOICES];
  logic [AW-1:0]         age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] start_q, start_d;
  logic                  steal_q, steal_d;

  logic [NUM_KEYS-1:0]   press, rel, cand, grant_bit;
  logic                  grant_valid;
  logic [KW-1:0]         grant_key;
  logic [NUM_VOICES-1:0] free;
  logic                  any_free, found;
  logic [AW-1:0]         sel;
  logic [AW-1:0]         best_age;

  always_comb begin
    press = keys & ~key_q;
    rel   = key_q & ~keys;

    // A pending key only counts while it is still held.
    cand        = pending_q & keys;
    grant_valid = 1'b0;
    grant_key   = '0;
    grant_bit   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (cand[i] && !grant_valid) begin
        grant_valid  = 1'b1;
        grant_key    = KW'(i);
        grant_bit[i] = 1'b1;
      end
    end

    // A voice whose key is released this edge can be reused immediately.
    for (int v = 0; v < NUM_VOICES; v++) begin
      free[v] = ~active_q[v] | rel[vkey_q[v]];
    end
    any_free = |free;

    sel   = '0;
    found = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (free[v] && !found) begin
        sel   = AW'(v);
        found = 1'b1;
      end
    end
    // No free voice: take the oldest. A strict compare keeps the lowest index on ties.
    best_age = age_q[0];
    if (!any_free) begin
      for (int v = 1; v < NUM_VOICES; v++) begin
        if (age_q[v] > best_age) begin
          best_age = age_q[v];
          sel      = AW'(v);
        end
      end
    end

    key_d     = keys;
    pending_d = ((pending_q & ~grant_bit) | press) & keys;
    active_d  = active_q;
    vkey_d    = vkey_q;
    age_d     = age_q;
    start_d   = '0;
    steal_d   = 1'b0;

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v] && rel[vkey_q[v]]) begin
        active_d[v] = 1'b0;
      end
    end

    if (grant_valid) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (active_d[v] && (AW'(v) != sel) && (age_q[v] != AW'(NUM_VOICES - 1))) begin
          age_d[v] = age_q[v] + AW'(1);
        end
      end
      // Grant overrides a release of the previous key on the same voice.
      active_d[sel] = 1'b1;
      vkey_d[sel]   = grant_key;
      age_d[sel]    = '0;
      start_d[sel]  = 1'b1;
      steal_d       = ~any_free;
    end

    // Flush, but track held keys so they produce no press edge on re-enable.
    if (!enable) begin
      pending_d = '0;
      active_d  = '0;
      start_d   = '0;
      steal_d   = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_d[v] = '0;
        age_d[v]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      key_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      start_q   <= '0;
      steal_q   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      key_q     <= key_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      start_q   <= start_d;
      steal_q   <= steal_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= vkey_d[v];
        age_q[v]  <= age_d[v];
      end
    end
  end

  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KW +: KW] = vkey_q[v];
    end
  end

  assign voice_active = active_q;
  assign voice_start  = start_q;
  assign steal        = steal_q;
  assign busy         = |pending_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios followed by random key traffic,
// each edge checked against a queue-free behavioural model of the allocator.
module tb_voice_allocator;

  localparam int NK = 8;
  localparam int NV = 4;

  logic        clk;
  logic        n_rst;
  logic        enable;
  logic [7:0]  keys;
  logic [3:0]  voice_active;
  logic [11:0] voice_key;
  logic [3:0]  voice_start;
  logic        steal;
  logic        busy;

  int n_cmp;
  int n_fail;

  // Reference state
  bit m_keyq [NK];
  bit m_pend [NK];
  bit m_act  [NV];
  int m_vkey [NV];
  int m_age  [NV];
  bit m_start[NV];
  bit m_steal;

  voice_allocator #(
    .NUM_KEYS  (8),
    .NUM_VOICES(4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .keys        (keys),
    .voice_active(voice_active),
    .voice_key   (voice_key),
    .voice_start (voice_start),
    .steal       (steal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_act[v]   = 1'b0;
      m_vkey[v]  = 0;
      m_age[v]   = 0;
      m_start[v] = 1'b0;
    end
    m_steal = 1'b0;
  endtask

  task automatic model_edge(input bit rn, input bit en, input logic [7:0] k);
    bit prs[NK];
    bit rls[NK];
    bit stay[NV];
    int g;
    int sel;
    if (!rn) begin
      model_clear();
      for (int i = 0; i < NK; i++) m_keyq[i] = 1'b0;
    end else if (!en) begin
      model_clear();
      for (int i = 0; i < NK; i++) m_keyq[i] = k[i];
    end else begin
      for (int i = 0; i < NK; i++) begin
        prs[i] = k[i] && !m_keyq[i];
        rls[i] = m_keyq[i] && !k[i];
      end
      g = -1;
      for (int i = 0; i < NK; i++) if (g < 0 && m_pend[i] && k[i]) g = i;
      for (int i = 0; i < NK; i++) begin
        m_pend[i] = ((m_pend[i] && i != g) || prs[i]) && k[i];
        m_keyq[i] = k[i];
      end
      for (int v = 0; v < NV; v++) begin
        stay[v]    = m_act[v] && !rls[m_vkey[v]];
        m_start[v] = 1'b0;
      end
      m_steal = 1'b0;
      if (g >= 0) begin
        sel = -1;
        for (int v = 0; v < NV; v++) if (sel < 0 && !stay[v]) sel = v;
        if (sel < 0) begin
          sel = 0;
          for (int v = 1; v < NV; v++) if (m_age[v] > m_age[sel]) sel = v;
          m_steal = 1'b1;
        end
        for (int v = 0; v < NV; v++)
          if (stay[v] && v != sel) m_age[v] = (m_age[v] + 1 > NV - 1) ? NV - 1 : m_age[v] + 1;
        stay[sel]    = 1'b1;
        m_vkey[sel]  = g;
        m_age[sel]   = 0;
        m_start[sel] = 1'b1;
      end
      for (int v = 0; v < NV; v++) m_act[v] = stay[v];
    end
  endtask

  task automatic compare_model();
    logic [3:0]  e_va;
    logic [3:0]  e_vs;
    logic [11:0] e_vk;
    logic        e_busy;
    e_busy = 1'b0;
    for (int i = 0; i < NK; i++) if (m_pend[i]) e_busy = 1'b1;
    for (int v = 0; v < NV; v++) begin
      e_va[v]         = m_act[v];
      e_vs[v]         = m_start[v];
      e_vk[v*3 +: 3]  = 3'(m_vkey[v]);
    end
    check("model_voice_active", 32'(voice_active), 32'(e_va));
    check("model_voice_key", 32'(voice_key), 32'(e_vk));
    check("model_voice_start", 32'(voice_start), 32'(e_vs));
    check("model_steal", 32'(steal), 32'(m_steal));
    check("model_busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic step(input bit rn, input bit en, input logic [7:0] k);
    n_rst  = rn;
    enable = en;
    keys   = k;
    @(posedge clk);
    model_edge(rn, en, k);
    #1;
    compare_model();
  endtask

  initial begin
    logic [7:0] rk;
    bit         rrn;
    bit         ren;
    n_cmp  = 0;
    n_fail = 0;
    n_rst  = 1'b0;
    enable = 1'b0;
    keys   = 8'h00;
    for (int i = 0; i < NK; i++) m_keyq[i] = 1'b0;
    model_clear();

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("rst_voice_active", 32'(voice_active), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_voice_key", 32'(voice_key), 32'h0);

    // Single key press and release
    step(1'b1, 1'b1, 8'h01);
    check("t1_pending", 32'(busy), 32'h1);
    check("t1_not_yet_active", 32'(voice_active), 32'h0);
    step(1'b1, 1'b1, 8'h01);
    check("t1_active", 32'(voice_active), 32'h1);
    check("t1_start", 32'(voice_start), 32'h1);
    check("t1_key", 32'(voice_key[2:0]), 32'h0);
    step(1'b1, 1'b1, 8'h01);
    check("t1_start_one_cycle", 32'(voice_start), 32'h0);
    step(1'b1, 1'b1, 8'h00);
    check("t1_released", 32'(voice_active), 32'h0);

    // Four keys at once: one grant per edge
    step(1'b1, 1'b1, 8'h0F);
    check("t2_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'h0F);
      check("t2_start", 32'(voice_start), 32'(1 << i));
      check("t2_no_steal", 32'(steal), 32'h0);
      check("t2_busy_seq", 32'(busy), (i < 3) ? 32'h1 : 32'h0);
    end
    check("t2_active", 32'(voice_active), 32'hF);
    check("t2_keys", 32'(voice_key), 32'h688);

    // Fifth key steals the oldest voice
    step(1'b1, 1'b1, 8'h1F);
    step(1'b1, 1'b1, 8'h1F);
    check("t3_steal", 32'(steal), 32'h1);
    check("t3_start", 32'(voice_start), 32'h1);
    check("t3_key", 32'(voice_key), 32'h68C);
    step(1'b1, 1'b1, 8'h1F);
    check("t3_steal_one_cycle", 32'(steal), 32'h0);
    step(1'b1, 1'b1, 8'h1E);
    check("t3_stolen_release_noop", 32'(voice_active), 32'hF);
    check("t3_keys_kept", 32'(voice_key), 32'h68C);

    // Release and grant on the same voice at the same edge
    step(1'b1, 1'b1, 8'h5E);
    step(1'b1, 1'b1, 8'h5A);
    check("t5_active", 32'(voice_active), 32'hF);
    check("t5_key2", 32'(voice_key[8:6]), 32'h6);
    check("t5_no_steal", 32'(steal), 32'h0);
    check("t5_start", 32'(voice_start), 32'h4);

    // Key 5 pressed and released while queued behind key 0
    step(1'b1, 1'b1, 8'h7B);
    step(1'b1, 1'b1, 8'h5B);
    check("t4_pending_cleared", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h5B);
      check("t4_no_start", 32'(voice_start), 32'h0);
    end

    // Reset and disable mid-note
    step(1'b0, 1'b1, 8'h5B);
    check("t6_rst_active", 32'(voice_active), 32'h0);
    check("t6_rst_key", 32'(voice_key), 32'h0);
    step(1'b1, 1'b1, 8'h5B);
    step(1'b1, 1'b1, 8'h5B);
    step(1'b1, 1'b0, 8'h5B);
    check("t6_dis_active", 32'(voice_active), 32'h0);
    check("t6_dis_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h5B);
      check("t6_no_grant", 32'(voice_active), 32'h0);
      check("t6_no_busy", 32'(busy), 32'h0);
    end

    // Random key traffic with occasional reset/disable
    rk = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) rk[$urandom_range(0, 7)] = ~rk[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) rk ^= 8'(1 << $urandom_range(0, 7));
      rrn = ($urandom_range(0, 59) != 0);
      ren = ($urandom_range(0, 39) != 0);
      step(rrn, ren, rk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
